// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester mailbox and uart_tx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int N_CH = 4,
    parameter int DW   = 16
);
    logic [N_CH-1:0]    req_valid;
    logic [N_CH*DW-1:0] req_data;
    logic [N_CH-1:0]    req_ready;
    logic [N_CH-1:0]    done;
    logic               err;
    logic [DW-1:0]      tx_data;
    logic               tx_wr_en;
    logic               tx_busy;
    logic [1:0]         grant_id;
    logic               active;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, done, err, tx_data, tx_wr_en, grant_id, active
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, done, err, tx_data, tx_wr_en, grant_id, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one uart_tx between four mailboxes
module uart_tx_arbiter #(
    parameter int N_CH         = 4,
    parameter int DW           = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [3:0] TMO = 4'(BUSY_TIMEOUT);

    state_t          state, state_next;
    logic [N_CH-1:0] full;
    logic [DW-1:0]   mbox [N_CH];
    logic [1:0]      ptr;
    logic [1:0]      grant;
    logic [1:0]      winner;
    logic            any_full;
    logic [3:0]      cnt, cnt_next;
    logic            grant_now, finish_ok, finish_err;
    logic [DW-1:0]   tx_data_r;
    logic            wr_en_r;
    logic [N_CH-1:0] done_r;
    logic            err_r;

    // Scan full[] starting at ptr; the first hit wins.
    always_comb begin
        logic [1:0] idx;
        winner   = '0;
        any_full = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ptr + 2'(k);
            if (!any_full && full[idx]) begin
                winner   = idx;
                any_full = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_now  = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state)
            IDLE: begin
                if (any_full) begin
                    grant_now  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == TMO) begin
                    finish_err = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    finish_ok  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            ptr       <= '0;
            grant     <= '0;
            tx_data_r <= '0;
            wr_en_r   <= 1'b0;
            done_r    <= '0;
            err_r     <= 1'b0;
            cnt       <= '0;
        end else begin
            cnt     <= cnt_next;
            wr_en_r <= grant_now;
            err_r   <= finish_err;
            done_r  <= finish_ok ? (N_CH'(1) << grant) : '0;
            if (grant_now) begin
                grant     <= winner;
                tx_data_r <= mbox[winner];
                ptr       <= winner + 2'd1;
            end
            // A full mailbox never loads, so set and clear cannot collide.
            for (int i = 0; i < N_CH; i++) begin
                if (bus.req_valid[i] && !full[i]) begin
                    full[i] <= 1'b1;
                end else if ((finish_ok || finish_err) && grant == 2'(i)) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (bus.req_valid[i] && !full[i]) begin
                mbox[i] <= bus.req_data[i*DW +: DW];
            end
        end
    end

    assign bus.req_ready = ~full;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_wr_en  = wr_en_r;
    assign bus.grant_id  = grant;
    assign bus.active    = (state != IDLE);
endmodule
